// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and FSM state encoding for the multi-cycle ALU
//
// Contents:
//   OP_AND..OP_NOR  3-bit op codes presented on alu_mc.op
//   state_t         control FSM states (S_IDLE, S_MUL_RUN)
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative unsigned shift-add multiplier, MUL_BITS bits per cycle
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst_n    in   1        synchronous active-low reset; aborts a running multiply
//   start    in   1        latch a/b and begin; ignored bits of state are reloaded
//   a, b     in   WIDTH    unsigned operands (sampled only on start)
//   done     out  1        high in the last iteration cycle; product is valid then
//   product  out  2*WIDTH  a*b, combinational view of the accumulator after this cycle's add
module alu_mul_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int STEPS = WIDTH / MUL_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    logic                 busy;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   a_sh;      // multiplicand pre-shifted to the current bit position
    logic [WIDTH-1:0]     b_sh;      // multiplier, low MUL_BITS bits are retired each cycle
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_next;

    // Partial product of the multiplicand and the current multiplier chunk,
    // built as a small shift-add tree rather than a generic multiplier.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (b_sh[i]) begin
                partial = partial + (a_sh << i);
            end
        end
    end

    assign acc_next = acc + partial;
    assign product  = acc_next;
    assign done     = busy && (count == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            count <= '0;
            acc   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CW'(STEPS);
            acc   <= '0;
            a_sh  <= {{WIDTH{1'b0}}, a};
            b_sh  <= b;
        end else if (busy) begin
            acc   <= acc_next;
            a_sh  <= a_sh << MUL_BITS;
            b_sh  <= b_sh >> MUL_BITS;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - handshaked multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      op/a/b valid
//   in_ready   out  1      block can accept this cycle
//   op         in   3      operation code (see alu_pkg)
//   a, b       in   WIDTH  two's complement operands
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer takes result
//   result     out  WIDTH  op result (MUL: low half of product)
//   result_hi  out  WIDTH  MUL: high half of product, 0 otherwise
//   zero       out  1      result == 0
//   ovf        out  1      signed overflow for ADD/SUB, 0 otherwise
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_hi,
    output logic              zero,
    output logic              ovf
);

    state_t              state, state_next;
    logic                accept;
    logic                mul_start;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_product;

    logic [WIDTH-1:0]    sum, diff;
    logic                slt;
    logic [WIDTH-1:0]    alu_res;
    logic                alu_ovf;

    logic                valid_next;
    logic [WIDTH-1:0]    res_next, hi_next;
    logic                zero_next, ovf_next;

    // A new op may enter only when the FSM is idle and the output register
    // is either empty or being emptied this same cycle.
    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath. MUL has no single-cycle result; it falls to zero here.
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        slt     = $signed(a) < $signed(b);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Next-state and output-register next values.
    always_comb begin
        state_next = state;
        valid_next = out_valid;
        res_next   = result;
        hi_next    = result_hi;
        zero_next  = zero;
        ovf_next   = ovf;

        // Retire a taken result; a load below overrides this in the same cycle.
        if (out_valid && out_ready) begin
            valid_next = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_next = S_MUL_RUN;
                    end else begin
                        valid_next = 1'b1;
                        res_next   = alu_res;
                        hi_next    = '0;
                        zero_next  = (alu_res == '0);
                        ovf_next   = alu_ovf;
                    end
                end
            end
            S_MUL_RUN: begin
                if (mul_done) begin
                    state_next = S_IDLE;
                    valid_next = 1'b1;
                    res_next   = mul_product[WIDTH-1:0];
                    hi_next    = mul_product[2*WIDTH-1:WIDTH];
                    zero_next  = (mul_product[WIDTH-1:0] == '0);
                    ovf_next   = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= valid_next;
            result    <= res_next;
            result_hi <= hi_next;
            zero      <= zero_next;
            ovf       <= ovf_next;
        end
    end

endmodule
